// File: rtl/simon_pkg.sv
// Shared definitions for the Simon colour-sequence engine: colour codes,
// engine state encoding and the LFSR feedback mask.
package simon_pkg;

  localparam logic [1:0] COLOR_U = 2'd0;
  localparam logic [1:0] COLOR_R = 2'd1;
  localparam logic [1:0] COLOR_D = 2'd2;
  localparam logic [1:0] COLOR_L = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GAP   = 2'd2,
    ST_INPUT = 2'd3
  } state_e;

  // Galois taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Galois LFSR that supplies random colours.
// Ports:
//   board_clk  clock
//   Reset      async active-high reset, loads SEED
//   q          current LFSR state
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        board_clk,
  input  logic        Reset,
  output logic [15:0] q
);

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon colour-sequence engine: grows a random colour sequence, plays it back
// with internal step/gap timing and checks the player's guesses.
// Build option: SIMON_SEQ_NO_REPEAT_EN forces consecutive colours to differ.
// Ports:
//   board_clk, Reset            clock, async active-high reset
//   clear                       synchronous restart (length 0, IDLE)
//   append, play_start          one-cycle commands, honoured only in IDLE
//   guess_valid, guess_color    debounced button press
//   play_valid, play_color      colour currently lit
//   busy, awaiting              playing back / waiting for guesses
//   guess_ok, guess_bad,
//   round_done                  one-cycle verdict pulses
//   length, full                sequence length and full flag
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       board_clk,
  input  logic                       Reset,
  input  logic                       clear,
  input  logic                       append,
  input  logic                       play_start,
  input  logic                       guess_valid,
  input  logic [1:0]                 guess_color,
  output logic                       play_valid,
  output logic [1:0]                 play_color,
  output logic                       busy,
  output logic                       awaiting,
  output logic                       guess_ok,
  output logic                       guess_bad,
  output logic                       round_done,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       full
);

  localparam int unsigned IW   = $clog2(MAX_LEN);
  localparam int unsigned LW   = IW + 1;
  localparam int unsigned TMAX = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e          state_q;
  logic [LW-1:0]   length_q;
  logic            full_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   timer_q;
  logic            play_valid_q, busy_q, awaiting_q;
  logic            guess_ok_q, guess_bad_q, round_done_q;
  logic [1:0]      play_color_q;
  logic [1:0]      mem_q [MAX_LEN];

  logic [15:0]     lfsr_q;
  logic [1:0]      lfsr_col;
  logic [13:0]     lfsr_unused;
  logic [1:0]      new_col;
  logic            mem_we;
  logic            last_idx;

  simon_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .board_clk (board_clk),
    .Reset     (Reset),
    .q         (lfsr_q)
  );

  assign lfsr_col    = lfsr_q[1:0];
  assign lfsr_unused = lfsr_q[15:2];

`ifdef SIMON_SEQ_NO_REPEAT_EN
  logic [IW-1:0] prev_idx;
  assign prev_idx = IW'(length_q - LW'(1));

  // Bump the colour by one when it would repeat the previous entry
  always_comb begin
    new_col = lfsr_col;
    if ((length_q != '0) && (lfsr_col == mem_q[prev_idx])) begin
      new_col = lfsr_col + 2'd1;
    end
  end
`else
  assign new_col = lfsr_col;
`endif

  assign mem_we   = (state_q == ST_IDLE) && !clear && append && !full_q;
  assign last_idx = (LW'(idx_q) == (length_q - LW'(1)));

  // Sequence storage; contents are don't-care until written
  always_ff @(posedge board_clk) begin
    if (mem_we) begin
      mem_q[length_q[IW-1:0]] <= new_col;
    end
  end

  // Engine FSM with registered outputs
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      length_q     <= '0;
      full_q       <= 1'b0;
      idx_q        <= '0;
      timer_q      <= '0;
      play_valid_q <= 1'b0;
      play_color_q <= COLOR_U;
      busy_q       <= 1'b0;
      awaiting_q   <= 1'b0;
      guess_ok_q   <= 1'b0;
      guess_bad_q  <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      guess_ok_q   <= 1'b0;
      guess_bad_q  <= 1'b0;
      round_done_q <= 1'b0;
      if (clear) begin
        state_q      <= ST_IDLE;
        length_q     <= '0;
        full_q       <= 1'b0;
        play_valid_q <= 1'b0;
        busy_q       <= 1'b0;
        awaiting_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (append && !full_q) begin
              length_q <= length_q + LW'(1);
              full_q   <= (length_q == LW'(MAX_LEN - 1));
            end else if (play_start && (length_q != '0)) begin
              idx_q        <= '0;
              timer_q      <= '0;
              state_q      <= ST_SHOW;
              play_valid_q <= 1'b1;
              play_color_q <= mem_q[0];
              busy_q       <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (timer_q == TW'(STEP_CYCLES - 1)) begin
              timer_q      <= '0;
              state_q      <= ST_GAP;
              play_valid_q <= 1'b0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          ST_GAP: begin
            if (timer_q == TW'(GAP_CYCLES - 1)) begin
              timer_q <= '0;
              if (last_idx) begin
                idx_q      <= '0;
                state_q    <= ST_INPUT;
                busy_q     <= 1'b0;
                awaiting_q <= 1'b1;
              end else begin
                idx_q        <= idx_q + IW'(1);
                state_q      <= ST_SHOW;
                play_valid_q <= 1'b1;
                play_color_q <= mem_q[idx_q + IW'(1)];
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          ST_INPUT: begin
            if (guess_valid) begin
              if (guess_color != mem_q[idx_q]) begin
                guess_bad_q <= 1'b1;
                state_q     <= ST_IDLE;
                awaiting_q  <= 1'b0;
              end else if (last_idx) begin
                round_done_q <= 1'b1;
                state_q      <= ST_IDLE;
                awaiting_q   <= 1'b0;
              end else begin
                guess_ok_q <= 1'b1;
                idx_q      <= idx_q + IW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign play_valid = play_valid_q;
  assign play_color = play_color_q;
  assign busy       = busy_q;
  assign awaiting   = awaiting_q;
  assign guess_ok   = guess_ok_q;
  assign guess_bad  = guess_bad_q;
  assign round_done = round_done_q;
  assign length     = length_q;
  assign full       = full_q;

endmodule
